// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (IF)
// and load/store (LS), sequencing each access over MEM_LAT cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_valid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_d_in,
    output logic                  mem_rwbar,
    input  logic [DATA_WIDTH-1:0] mem_d_out,
    output logic                  busy
);

    // Handshake: a requester holds req and operands until its gnt pulse; the access is
    // then committed, and exactly one valid pulse follows MEM_LAT cycles after the grant.

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cur_ls;
    logic             last_ls;
    logic             pick_if;
    logic             pick_ls;
    logic             acc_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        pick_if   = if_req && (!ls_req || last_ls);
        pick_ls   = ls_req && (!if_req || !last_ls);
        acc_done  = (state == ACCESS) && (cnt == '0);
        state_nxt = state;
        case (state)
            IDLE:    if (pick_if || pick_ls) state_nxt = ACCESS;
            ACCESS:  if (acc_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        if_valid = (state == RESP) && !cur_ls;
        ls_valid = (state == RESP) && cur_ls;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mem_addr  <= '0;
            mem_d_in  <= '0;
            mem_rwbar <= 1'b1;
            cnt       <= '0;
            cur_ls    <= 1'b0;
            last_ls   <= 1'b1;
        end else begin
            if_gnt <= 1'b0;
            ls_gnt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_if || pick_ls) begin
                        cur_ls  <= pick_ls;
                        last_ls <= pick_ls;
                        if_gnt  <= pick_if;
                        ls_gnt  <= pick_ls;
                        cnt     <= CNT_W'(MEM_LAT - 1);
                        if (pick_ls) begin
                            mem_addr  <= ls_addr;
                            mem_d_in  <= ls_wdata;
                            mem_rwbar <= ~ls_we;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_rwbar <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (acc_done) begin
                        // mem_rwbar still reflects the access kind on its final edge.
                        if (mem_rwbar) begin
                            if (cur_ls) ls_rdata <= mem_d_out;
                            else        if_rdata <= mem_d_out;
                        end
                        mem_rwbar <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
